mem_wb_buffer: RTL and testbench
================================

# mem_wb_buffer

- Pipeline register between the memory stage and the write-back stage.
- Captures the memory-stage results and control, performs the MemtoReg write-back select at capture, and presents one write-back entry per cycle to the register file.
- Implemented as a two-entry skid buffer with a valid/ready handshake, so a stalled write-back never drops a memory result and never cuts throughput.
- Sits directly downstream of the EX/MEM buffer and the data memory.

## Interface
Parameters:
- DATA_W, 32, data path width
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  memory stage presents an entry
- in_ready  out  1  buffer accepts the entry this cycle
- in_reg_write  in  1  RegWrite control
- in_mem_to_reg  in  1  1 selects memory read data, 0 selects ALU result
- in_rd_data  in  DATA_W  data memory read data
- in_alu_result  in  DATA_W  ALU result / memory address
- in_write_reg  in  REG_AW  destination register
- flush  in  1  discard all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes the head entry
- out_reg_write  out  1  register-file write enable
- out_write_data  out  DATA_W  selected write-back data
- out_write_reg  out  REG_AW  destination register

## Operation
- Accept: in_valid && in_ready.
- Consume: out_valid && out_ready.
- Stored per entry: reg_write, write_data, write_reg.
  - write_data = in_mem_to_reg ? in_rd_data : in_alu_result, selected at capture.
  - reg_write is forced to 0 at capture when in_write_reg == 0, so writes to $zero are suppressed.
- Internal storage: main register (head) and skid register, each with a valid bit.
- States, encoded by the valid bits:
  - EMPTY: no entries held.
    - Accept → ONE.
  - ONE: main holds one entry.
    - Accept and consume → ONE; main reloads with the new entry.
    - Accept without consume → FULL; the new entry goes to skid.
    - Consume without accept → EMPTY.
  - FULL: main and skid both hold entries.
    - Accept is impossible because in_ready = 0.
    - Consume → ONE; skid moves into main.
- Entries leave in arrival order; none are reordered or duplicated.
- in_ready = !skid_valid && !rst. It is derived from registered state only and has no combinational path from out_ready.
- out_valid = main_valid.
- out_reg_write = main_valid && main.reg_write.
- out_write_data and out_write_reg reflect main and are held stable while out_valid && !out_ready.
- flush: both valid bits clear on the next edge and the state goes to EMPTY.
  - An entry offered in the same cycle is dropped.
  - flush has priority over accept and consume.
- Reset: main_valid = skid_valid = 0; all stored data and register fields = 0.
  - After reset, out_valid = 0, out_reg_write = 0, out_write_data = 0 and out_write_reg = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
  - Reset during any state discards all entries.

## Timing
- Latency: an entry accepted at edge N is on the outputs after edge N, with out_valid = 1 in cycle N+1.
- Throughput: 1 entry/cycle when out_ready is held high.
- Backpressure reaches the input after one cycle: the first stalled cycle absorbs one entry in skid, then in_ready drops.
- in_ready rises in the cycle after the consume that empties skid.

## Configuration
- MEM_WB_FWD_EN defined: adds output ports for the hazard/forwarding unit.
  - fwd_en (1) = out_valid && out_reg_write
  - fwd_reg (REG_AW) = main write_reg
  - fwd_data (DATA_W) = main write_data
  - These ports go to 0 in the same reset cycles as out_valid.
- MEM_WB_FWD_EN undefined: the ports do not exist and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - the wb_entry_t struct (reg_write, write_data, write_reg)
  - DATA_W and REG_AW defaults
  - the zero-register constant REG_ZERO.
- One natural sub-module, wb_skid_reg: a generic two-entry valid/ready skid register parameterised on payload width.
- mem_wb_buffer instantiates wb_skid_reg and adds the write-back select, zero-register suppression and forwarding taps.

## Test plan
- Streaming: reset, then 8 back-to-back entries with out_ready=1 and write_reg=1..8, mem_to_reg alternating.
  - Required: outputs match 1 cycle later in order.
  - Required: data equals rd_data on odd entries and alu_result on even entries.
- Stall: while streaming, drop out_ready for 3 cycles.
  - Required: in_ready falls one cycle after the stall starts.
  - Required: exactly 2 entries are held and released in order when out_ready returns; none lost.
- Zero register: entry with write_reg=0, reg_write=1, alu_result=0xDEADBEEF.
  - Required: out_valid=1 and out_reg_write=0.
- Flush in FULL with in_valid=1 in the same cycle.
  - Required: out_valid=0 next cycle, in_ready=1, and the offered entry never appears.
- Mid-operation reset with 2 entries held.
  - Required: all outputs 0 while rst=1, in_ready=0 during reset and 1 one cycle after release.
- MEM_WB_FWD_EN: entry with write_reg=5 and data=0x1234.
  - Required: fwd_en=1, fwd_reg=5, fwd_data=0x1234 while the entry is at the head.
  - Required: fwd_en=0 after the entry is consumed.

Source files
------------

// File: rtl/mem_wb_buffer_pkg.sv
// mem_wb_buffer_pkg: shared pipeline widths, zero-register constant and write-back entry type
package mem_wb_buffer_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic              reg_write;
        logic [DATA_W-1:0] write_data;
        logic [REG_AW-1:0] write_reg;
    } wb_entry_t;
endpackage

// File: rtl/wb_skid_reg.sv
// wb_skid_reg: generic two-entry valid/ready skid register (main = head, skid = overflow)
module wb_skid_reg #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         accept, consume;
    always_comb begin
        in_ready     = !skid_valid_q && !rst;
        out_valid    = main_valid_q;
        out_data     = main_q;
        accept       = in_valid && in_ready;
        consume      = main_valid_q && out_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (consume) begin
            main_valid_d = skid_valid_q || accept;
            main_d       = skid_valid_q ? skid_q : (accept ? in_data : main_q);
            skid_valid_d = 1'b0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            skid_valid_d = main_valid_q;
            main_d       = main_valid_q ? main_q : in_data;
            skid_d       = main_valid_q ? in_data : skid_q;
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end
endmodule

// File: rtl/mem_wb_buffer.sv
// mem_wb_buffer: MEM/WB skid pipeline register with write-back select; MEM_WB_FWD_EN adds forwarding taps
module mem_wb_buffer
    import mem_wb_buffer_pkg::*;
#(
    parameter int DATA_W = mem_wb_buffer_pkg::DATA_W,
    parameter int REG_AW = mem_wb_buffer_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_rd_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_write_reg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_write_data,
`ifdef MEM_WB_FWD_EN
    output logic [REG_AW-1:0] out_write_reg,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`else
    output logic [REG_AW-1:0] out_write_reg
`endif
);
    localparam int PW = 1 + DATA_W + REG_AW;
    logic [PW-1:0]     cap, head;
    logic [DATA_W-1:0] cap_data;
    logic              cap_we, head_we;
    always_comb begin
        cap_data = in_mem_to_reg ? in_rd_data : in_alu_result;
        cap_we   = in_reg_write && (in_write_reg != REG_AW'(REG_ZERO));
        cap      = {cap_we, cap_data, in_write_reg};
        {head_we, out_write_data, out_write_reg} = head;
        out_reg_write = out_valid && head_we;
    end
    wb_skid_reg #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (cap),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );
`ifdef MEM_WB_FWD_EN
    assign fwd_en   = out_valid && out_reg_write;
    assign fwd_reg  = out_write_reg;
    assign fwd_data = out_write_data;
`endif
endmodule

// File: tb/tb_mem_wb_buffer.sv
// tb_mem_wb_buffer: table vectors, directed corner sequences and random traffic against a queue model
module tb_mem_wb_buffer;
    import mem_wb_buffer_pkg::*;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_reg_write, in_mem_to_reg, flush;
    logic        out_valid, out_ready, out_reg_write;
    logic [31:0] in_rd_data, in_alu_result, out_write_data;
    logic [4:0]  in_write_reg, out_write_reg;
`ifdef MEM_WB_FWD_EN
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif
    int          n_tests = 0, n_fail = 0;
    wb_entry_t   q[$];
    typedef struct {
        logic        iv, m2r, rw;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic        ordy;
        logic        ev, ewe, cd;
        logic [31:0] ed;
        logic [4:0]  er;
        logic        erdy;
    } vec_t;
    vec_t tbl[10];
    always #5 clk = ~clk;
    mem_wb_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_rd_data(in_rd_data), .in_alu_result(in_alu_result), .in_write_reg(in_write_reg),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_write_data(out_write_data),
`ifdef MEM_WB_FWD_EN
        .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
        .out_write_reg(out_write_reg)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic check_model();
        chk("model out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("model in_ready", 64'(in_ready), 64'(!rst && q.size() < 2));
        if (q.size() > 0) begin
            chk("model out_reg_write", 64'(out_reg_write), 64'(q[0].reg_write));
            chk("model out_write_data", 64'(out_write_data), 64'(q[0].write_data));
            chk("model out_write_reg", 64'(out_write_reg), 64'(q[0].write_reg));
        end else
            chk("model out_reg_write idle", 64'(out_reg_write), 64'd0);
    endtask
    task automatic apply(input logic iv, m2r, rw, input logic [31:0] rd, alu, input logic [4:0] wr,
                         input logic ordy, fl, r);
        logic      acc, con;
        wb_entry_t e;
        in_valid = iv; in_mem_to_reg = m2r; in_reg_write = rw; in_rd_data = rd;
        in_alu_result = alu; in_write_reg = wr; out_ready = ordy; flush = fl; rst = r;
        acc = iv && !r && q.size() < 2;
        con = q.size() > 0 && ordy;
        e.reg_write  = rw && wr != 5'd0;
        e.write_data = m2r ? rd : alu;
        e.write_reg  = wr;
        @(posedge clk);
        #1;
        if (r || fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_model();
    endtask
    task automatic idle(input logic ordy);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
    endtask
    task automatic fill_full();
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'hA1, 5'd21, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'hA2, 5'd22, 1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        rst = 1'b1; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_rd_data = 0;
        in_alu_result = 0; in_write_reg = 0; flush = 0; out_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            logic [31:0] rd, alu;
            rd = 32'h1000 + 32'(i);
            alu = 32'h2000 + 32'(i);
            tbl[i-1] = '{1'b1, i[0], 1'b1, rd, alu, 5'(i), 1'b1,
                         1'b1, 1'b1, 1'b1, i[0] ? rd : alu, 5'(i), 1'b1};
        end
        tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h5555, 32'hDEADBEEF, 5'd0, 1'b1,
                   1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1,
                   1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1};
        do_reset();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_reg_write", 64'(out_reg_write), 64'd0);
        chk("reset out_write_data", 64'(out_write_data), 64'd0);
        chk("reset out_write_reg", 64'(out_write_reg), 64'd0);
        chk("reset release in_ready", 64'(in_ready), 64'd1);
        foreach (tbl[i]) begin
            apply(tbl[i].iv, tbl[i].m2r, tbl[i].rw, tbl[i].rd, tbl[i].alu, tbl[i].wr,
                  tbl[i].ordy, 1'b0, 1'b0);
            chk($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl[%0d] out_reg_write", i), 64'(out_reg_write), 64'(tbl[i].ewe));
            chk($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].erdy));
            if (tbl[i].cd) begin
                chk($sformatf("tbl[%0d] data", i), 64'(out_write_data), 64'(tbl[i].ed));
                chk($sformatf("tbl[%0d] reg", i), 64'(out_write_reg), 64'(tbl[i].er));
            end
        end
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h11, 5'd11, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h12, 5'd12, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h13, 5'd13, 1'b0, 1'b0, 1'b0);
        chk("stall in_ready drops", 64'(in_ready), 64'd0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h14, 5'd14, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h14, 5'd14, 1'b0, 1'b0, 1'b0);
        chk("stall head held", 64'(out_write_reg), 64'd12);
        chk("stall in_ready low", 64'(in_ready), 64'd0);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h14, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("stall release 2nd", 64'(out_write_reg), 64'd13);
        chk("stall in_ready rises", 64'(in_ready), 64'd1);
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h14, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("stall next entry", 64'(out_write_data), 64'h14);
        idle(1'b1);
        fill_full();
        apply(1'b1, 1'b1, 1'b1, 32'h99, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        chk("flush entry dropped", 64'(out_valid), 64'd0);
        fill_full();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst out_reg_write", 64'(out_reg_write), 64'd0);
        chk("midrst data", 64'(out_write_data), 64'd0);
        chk("midrst reg", 64'(out_write_reg), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst release in_ready", 64'(in_ready), 64'd1);
`ifdef MEM_WB_FWD_EN
        apply(1'b1, 1'b0, 1'b1, 32'h0, 32'h1234, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("fwd_en head", 64'(fwd_en), 64'd1);
        chk("fwd_reg head", 64'(fwd_reg), 64'd5);
        chk("fwd_data head", 64'(fwd_data), 64'h1234);
        idle(1'b1);
        chk("fwd_en consumed", 64'(fwd_en), 64'd0);
`endif
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
        end
        idle(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
